// File: rtl/sysid_verifier.sv
// Avalon-MM master that reads the system-ID slave (ID word, then timestamp) and checks both
// against build-time values. Optional periodic self-trigger under SYSID_VERIFIER_PERIODIC_EN.
module sysid_verifier #(
   parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
   parameter logic [31:0] EXPECTED_TS  = 32'd1618182670,
   parameter int unsigned READ_LATENCY = 0,
   parameter logic [15:0] PERIOD       = 16'd1000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic [7:0]  fail_count
);

   typedef enum logic [2:0] {StIdle, StRdId, StWtId, StRdTs, StWtTs, StCmp} state_t;

   localparam logic [1:0] Lat     = 2'(READ_LATENCY);
   localparam bit         ZeroLat = (READ_LATENCY == 0);

   state_t      state_q, state_d;
   logic [1:0]  lat_q, lat_d;
   logic [31:0] id_q, id_d, ts_q, ts_d;
   logic        id_ok_q, id_ok_d, ts_ok_q, ts_ok_d;
   logic        done_q, done_d;
   logic [7:0]  fail_q, fail_d;
   logic        trigger;

`ifdef SYSID_VERIFIER_PERIODIC_EN
   logic [15:0] timer_q, timer_d;
   logic        tick;

   // Held at PERIOD while busy, so every return to idle starts a fresh countdown.
   always_comb begin
      timer_d = timer_q;
      tick    = 1'b0;
      if (state_q != StIdle) begin
         timer_d = PERIOD;
      end else if (timer_q == 16'd0) begin
         tick = 1'b1;
      end else begin
         timer_d = timer_q - 16'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         timer_q <= PERIOD;
      end else begin
         timer_q <= timer_d;
      end
   end

   assign trigger = start | tick;
`else
   assign trigger = start;
`endif

   always_comb begin
      state_d     = state_q;
      lat_d       = lat_q;
      id_d        = id_q;
      ts_d        = ts_q;
      id_ok_d     = id_ok_q;
      ts_ok_d     = ts_ok_q;
      done_d      = 1'b0;
      fail_d      = fail_q;
      avm_read    = 1'b0;
      avm_address = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (trigger) state_d = StRdId;
         end
         StRdId: begin
            avm_read = 1'b1;
            if (!avm_waitrequest) begin
               if (ZeroLat) begin
                  id_d    = avm_readdata;
                  state_d = StRdTs;
               end else begin
                  lat_d   = 2'd1;
                  state_d = StWtId;
               end
            end
         end
         StWtId: begin
            if (lat_q == Lat) begin
               id_d    = avm_readdata;
               state_d = StRdTs;
            end else begin
               lat_d = lat_q + 2'd1;
            end
         end
         StRdTs: begin
            avm_read    = 1'b1;
            avm_address = 1'b1;
            if (!avm_waitrequest) begin
               if (ZeroLat) begin
                  ts_d    = avm_readdata;
                  state_d = StCmp;
               end else begin
                  lat_d   = 2'd1;
                  state_d = StWtTs;
               end
            end
         end
         StWtTs: begin
            if (lat_q == Lat) begin
               ts_d    = avm_readdata;
               state_d = StCmp;
            end else begin
               lat_d = lat_q + 2'd1;
            end
         end
         StCmp: begin
            id_ok_d = (id_q == EXPECTED_ID);
            ts_ok_d = (ts_q == EXPECTED_TS);
            done_d  = 1'b1;
            // Saturate rather than wrap so a long-running failure stays visible.
            if (!(id_ok_d && ts_ok_d) && (fail_q != 8'hFF)) fail_d = fail_q + 8'd1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         lat_q   <= 2'd0;
         id_q    <= 32'd0;
         ts_q    <= 32'd0;
         id_ok_q <= 1'b0;
         ts_ok_q <= 1'b0;
         done_q  <= 1'b0;
         fail_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         id_q    <= id_d;
         ts_q    <= ts_d;
         id_ok_q <= id_ok_d;
         ts_ok_q <= ts_ok_d;
         done_q  <= done_d;
         fail_q  <= fail_d;
      end
   end

   assign busy       = (state_q != StIdle);
   assign done       = done_q;
   assign id_ok      = id_ok_q;
   assign ts_ok      = ts_ok_q;
   assign id_value   = id_q;
   assign ts_value   = ts_q;
   assign fail_count = fail_q;

endmodule

// File: tb/tb_sysid_verifier.sv
// Scoreboard bench: two verifiers (read latency 0 and 2) against behavioural slave models.
module tb_sysid_verifier;

   localparam logic [31:0] EXP_ID = 32'h0000_0000;
   localparam logic [31:0] EXP_TS = 32'd1618182670;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic start = 1'b0;
   logic waitrequest = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   logic [31:0] mem_id = 32'd0, mem_ts = 32'd0, noise;
   always @(posedge clock) noise <= $urandom;

   logic        addr0, read0, busy0, done0, id_ok0, ts_ok0;
   logic [31:0] rdata0, idv0, tsv0;
   logic [7:0]  fc0;
   logic        addr2, read2, busy2, done2, id_ok2, ts_ok2;
   logic [31:0] rdata2, idv2, tsv2;
   logic [7:0]  fc2;

   sysid_verifier #(.READ_LATENCY(0)) u_dut0 (
      .clock(clock), .reset_n(reset_n), .start(start),
      .avm_address(addr0), .avm_read(read0), .avm_waitrequest(waitrequest),
      .avm_readdata(rdata0), .busy(busy0), .done(done0), .id_ok(id_ok0), .ts_ok(ts_ok0),
      .id_value(idv0), .ts_value(tsv0), .fail_count(fc0)
   );

   sysid_verifier #(.READ_LATENCY(2)) u_dut2 (
      .clock(clock), .reset_n(reset_n), .start(start),
      .avm_address(addr2), .avm_read(read2), .avm_waitrequest(waitrequest),
      .avm_readdata(rdata2), .busy(busy2), .done(done2), .id_ok(id_ok2), .ts_ok(ts_ok2),
      .id_value(idv2), .ts_value(tsv2), .fail_count(fc2)
   );

   // Slave models: data only in the cycle it is really valid, noise otherwise.
   assign rdata0 = (read0 && !waitrequest) ? (addr0 ? mem_ts : mem_id) : noise;

   logic [1:0] pv, pa;
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pv <= 2'b00;
         pa <= 2'b00;
      end else begin
         pv <= {pv[0], read2 & ~waitrequest};
         pa <= {pa[0], addr2};
      end
   end
   assign rdata2 = pv[1] ? (pa[1] ? mem_ts : mem_id) : noise;

   typedef struct {
      logic [31:0] id;
      logic [31:0] ts;
      logic        id_ok;
      logic        ts_ok;
      logic [7:0]  fc;
      int          due;
      int          rds;
   } exp_t;

   exp_t q0[$];
   exp_t q2[$];
   int n_checks = 0;
   int n_fail = 0;
   int model_fc = 0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_res(input string tag, input exp_t e, input logic [31:0] idv,
                            input logic [31:0] tsv, input logic iok, input logic tok,
                            input logic [7:0] fc, input logic bsy, input int rd);
      cmp({tag, "_id_value"}, idv, e.id);
      cmp({tag, "_ts_value"}, tsv, e.ts);
      cmp({tag, "_id_ok"}, 32'(iok), 32'(e.id_ok));
      cmp({tag, "_ts_ok"}, 32'(tok), 32'(e.ts_ok));
      cmp({tag, "_fail_count"}, 32'(fc), 32'(e.fc));
      cmp({tag, "_done_cycle"}, 32'(cyc), 32'(e.due));
      cmp({tag, "_read_cycles"}, 32'(rd), 32'(e.rds));
      cmp({tag, "_busy_at_done"}, 32'(bsy), 32'd0);
   endtask

   // Monitors: pop an expectation whenever a verifier presents done.
   int rd0 = 0, rd2 = 0;
   logic pd0 = 1'b0, pd2 = 1'b0;
   exp_t e0, e2;

   always @(negedge clock) begin
      if (!reset_n) begin
         rd0 = 0;
         pd0 = 1'b0;
      end else begin
         if (read0) rd0++;
         else cmp("dut0_addr_idle", 32'(addr0), 32'd0);
         if (done0) begin
            cmp("dut0_done_consecutive", 32'(pd0), 32'd0);
            if (q0.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL dut0_unexpected_done: got done=1 at cycle %0d, expected 0", cyc);
            end else begin
               e0 = q0.pop_front();
               check_res("dut0", e0, idv0, tsv0, id_ok0, ts_ok0, fc0, busy0, rd0);
            end
            rd0 = 0;
         end
         pd0 = done0;
      end
   end

   always @(negedge clock) begin
      if (!reset_n) begin
         rd2 = 0;
         pd2 = 1'b0;
      end else begin
         if (read2) rd2++;
         else cmp("dut2_addr_idle", 32'(addr2), 32'd0);
         if (done2) begin
            cmp("dut2_done_consecutive", 32'(pd2), 32'd0);
            if (q2.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL dut2_unexpected_done: got done=1 at cycle %0d, expected 0", cyc);
            end else begin
               e2 = q2.pop_front();
               check_res("dut2", e2, idv2, tsv2, id_ok2, ts_ok2, fc2, busy2, rd2);
            end
            rd2 = 0;
         end
         pd2 = done2;
      end
   end

   // Start a check in the current cycle; the first read is stalled for w cycles.
   task automatic issue(input logic [31:0] id, input logic [31:0] ts, input int w);
      exp_t e;
      mem_id = id;
      mem_ts = ts;
      e.id    = id;
      e.ts    = ts;
      e.id_ok = (id == EXP_ID);
      e.ts_ok = (ts == EXP_TS);
      if (!(e.id_ok && e.ts_ok) && model_fc < 255) model_fc++;
      e.fc  = 8'(model_fc);
      e.rds = 2 + w;
      e.due = cyc + 4 + w;
      q0.push_back(e);
      e.due = cyc + 4 + 2 * 2 + w;
      q2.push_back(e);
      start = 1'b1;
      waitrequest = (w > 0);
      @(posedge clock);
      #1 start = 1'b0;
      repeat (w) begin
         @(posedge clock);
         #1;
      end
      waitrequest = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((q0.size() != 0 || q2.size() != 0) && t < 200) begin
         @(posedge clock);
         #1;
         t++;
      end
      if (t >= 200) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout: got %0d/%0d results pending, expected 0", q0.size(), q2.size());
         q0.delete();
         q2.delete();
      end
   endtask

   task automatic check_reset_vals(input string tag);
      cmp({tag, "_read0"}, 32'(read0), 32'd0);
      cmp({tag, "_read2"}, 32'(read2), 32'd0);
      cmp({tag, "_addr0"}, 32'(addr0), 32'd0);
      cmp({tag, "_busy0"}, 32'(busy0), 32'd0);
      cmp({tag, "_busy2"}, 32'(busy2), 32'd0);
      cmp({tag, "_done0"}, 32'(done0), 32'd0);
      cmp({tag, "_done2"}, 32'(done2), 32'd0);
      cmp({tag, "_oks0"}, 32'({id_ok0, ts_ok0}), 32'd0);
      cmp({tag, "_oks2"}, 32'({id_ok2, ts_ok2}), 32'd0);
      cmp({tag, "_idv0"}, idv0, 32'd0);
      cmp({tag, "_tsv2"}, tsv2, 32'd0);
      cmp({tag, "_fc0"}, 32'(fc0), 32'd0);
      cmp({tag, "_fc2"}, 32'(fc2), 32'd0);
   endtask

   initial begin
      logic [31:0] rid, rts;
      int w;
      repeat (3) @(posedge clock);
      #1 check_reset_vals("reset");
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      // Directed: match, ID mismatch, backpressure on the first read.
      issue(EXP_ID, EXP_TS, 0);
      wait_idle();
      issue(32'h0000_0001, EXP_TS, 0);
      wait_idle();
      issue(EXP_ID, EXP_TS, 3);
      wait_idle();

      // Second start while busy must be ignored.
      issue(EXP_ID, 32'h1234_5678, 0);
      @(posedge clock);
      #1 start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      wait_idle();
      repeat (12) @(posedge clock);
      #1;

      for (int i = 0; i < 40; i++) begin
         rid = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
         rts = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
         w = $urandom_range(0, 3);
         issue(rid, rts, w);
         wait_idle();
      end

      // Asynchronous reset while reading the timestamp.
      issue(EXP_ID, EXP_TS, 0);
      @(posedge clock);
      #2 reset_n = 1'b0;
      #1 check_reset_vals("midreset");
      q0.delete();
      q2.delete();
      model_fc = 0;
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      repeat (12) @(posedge clock);
      #1;

      // Saturation of the failure counter.
      for (int i = 0; i < 300; i++) begin
         issue(32'h0000_0001, EXP_TS, 0);
         wait_idle();
      end
      cmp("saturate_fc0", 32'(fc0), 32'd255);
      cmp("saturate_fc2", 32'(fc2), 32'd255);

      repeat (5) @(posedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sysid_verifier.md
# sysid_verifier

Avalon-MM master that reads the system-ID slave and checks it against build-time expected values. On request, it reads the ID word (address 0), then the timestamp word (address 1), and compares both. It reports pass/fail flags and the captured values, and keeps a saturating failure count. It sits directly upstream of the system-ID slave on the control interconnect, and drives that slave's control port.

## Interface
Parameters:
- EXPECTED_ID, 32'h0000_0000, expected word at address 0
- EXPECTED_TS, 32'd1618182670, expected word at address 1
- READ_LATENCY, 0, cycles from accepted read to valid avm_readdata; legal range 0..3
- PERIOD, 16'd1000, idle cycles between automatic checks (used only with the Configuration macro)

Ports:
- clock  in  1  single system clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request a check; sampled only in IDLE
- avm_address  out  1  word address to the slave
- avm_read  out  1  read strobe
- avm_waitrequest  in  1  slave stall; tie 0 for the system-ID slave
- avm_readdata  in  32  slave read data
- busy  out  1  high while a check is in progress
- done  out  1  one-cycle pulse when results update
- id_ok  out  1  last captured ID == EXPECTED_ID
- ts_ok  out  1  last captured timestamp == EXPECTED_TS
- id_value  out  32  last captured ID
- ts_value  out  32  last captured timestamp
- fail_count  out  8  number of failed checks, saturating

## Operation
- States: IDLE, RD_ID, WT_ID, RD_TS, WT_TS, CMP.
- IDLE -> RD_ID when start=1.
- RD_ID: avm_address=0, avm_read=1, held until avm_waitrequest=0.
  - READ_LATENCY=0: capture avm_readdata into id_value in the accepting cycle; go to RD_TS.
  - Otherwise go to WT_ID.
- WT_ID: 2-bit latency counter. Capture id_value when the count reaches READ_LATENCY, then go to RD_TS.
- RD_TS / WT_TS: identical to RD_ID / WT_ID, but with avm_address=1, capturing into ts_value. Exit to CMP.
- CMP: one cycle, then IDLE. The exit edge performs all of:
  - registers id_ok and ts_ok;
  - pulses done;
  - increments fail_count if !(id_ok && ts_ok) and fail_count < 255; fail_count holds at 255.
- avm_read is 0 in every state other than RD_ID and RD_TS. avm_address is 0 when avm_read=0.
- start while busy: ignored, not queued.
- start held high: re-triggers on every entry to IDLE.
- id_value, ts_value, id_ok and ts_ok hold their values between checks.
- busy=1 in all states except IDLE.

## Timing
- Reset values: avm_read=0, avm_address=0, busy=0, done=0, id_ok=0, ts_ok=0, id_value=0, ts_value=0, fail_count=0, state IDLE.
- Reset is asynchronous: asserting reset_n mid-check drops avm_read immediately, and captured data is discarded.
- Cycle count with start high in cycle 0, waitrequest=0 and READ_LATENCY=0:
  - RD_ID in cycle 1;
  - RD_TS in cycle 2;
  - CMP in cycle 3;
  - done=1 and new results valid in cycle 4, with state back in IDLE.
- Each latency cycle adds 1 cycle per read: total = 4 + 2·READ_LATENCY.
- Each waitrequest cycle adds 1 cycle.
- done is never high for two consecutive cycles.

## Configuration
- SYSID_VERIFIER_PERIODIC_EN defined:
  - a 16-bit down-counter loads PERIOD on entry to IDLE (including on reset exit) and decrements each IDLE cycle;
  - reaching 0 triggers a check exactly as start does;
  - start still works, and an early start reloads the counter on return to IDLE;
  - PERIOD=0 means back-to-back checks.
- Not defined: counter logic is absent, and checks occur only on start.

## Test plan
- Match at latency 0: slave returns 0 @addr0 and 1618182670 @addr1; pulse start -> done in cycle 4, id_ok=1, ts_ok=1, fail_count=0.
- ID mismatch: slave returns 32'h0000_0001 @addr0 -> id_ok=0, ts_ok=1, id_value=1, fail_count=1. Repeat 300 checks -> fail_count=255.
- Backpressure and latency: READ_LATENCY=2, waitrequest high for 3 cycles on the first read -> done in cycle 4+4+3=11, avm_read deasserted during WT states, values correct.
- Start while busy: pulse start in cycles 0 and 2 -> exactly one done pulse, in cycle 4.
- Reset mid-check: assert reset_n=0 during RD_TS -> avm_read=0 within the same cycle, all outputs return to reset values, no done pulse.
- Periodic (macro defined, PERIOD=5): no start -> successive checks are spaced 5 idle cycles apart, first done at cycle 5+4 after reset release.
